// File: rtl/code_lock_pkg.sv
// Shared types and default constants for the code lock controller.
// Contents: controller state enum, default MAX_TRIES / OPEN_CYCLES /
// LOCKOUT_CYCLES values, and the helper that sizes the shared cycle timer.
package code_lock_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OPEN    = 2'd1,
      LOCKOUT = 2'd2
   } lock_state_e;

   localparam int unsigned MAX_TRIES_DEF      = 3;
   localparam int unsigned OPEN_CYCLES_DEF    = 8;
   localparam int unsigned LOCKOUT_CYCLES_DEF = 16;

   // Timer width: $clog2 of the longer window, held to at least one bit.
   function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return ($clog2(m) < 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that stops at zero.
// Ports: clk, rst_n (async, active-low), load_i/value_i (load a count),
//        enable_i (decrement by one), zero (count is zero).
module cycle_timer #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] value_i,
   input  logic         enable_i,
   output logic         zero
);

   logic [W-1:0] count_q, count_d;

   // Load has priority; decrement stops at zero so the count never underflows.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = value_i;
      end else if (enable_i && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/code_lock_ctrl.sv
// Code lock controller: opens the lock for OPEN_CYCLES on a matching code,
// counts consecutive mismatches, and enters a LOCKOUT_CYCLES lockout after
// MAX_TRIES of them.
// Ports: clk, rst_n (async, active-low), check_i (entry complete strobe),
//        equal_i (comparator result), clear_i (relock while open),
//        unlocked_o, fail_o, locked_out_o, busy_o, tries_o.
// Optional: CODE_LOCK_ALARM_EN adds alarm_clr_i and alarm_o (sticky alarm
//        raised on lockout entry).
module code_lock_ctrl
   import code_lock_pkg::*;
#(
   parameter int unsigned MAX_TRIES      = MAX_TRIES_DEF,
   parameter int unsigned OPEN_CYCLES    = OPEN_CYCLES_DEF,
   parameter int unsigned LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             check_i,
   input  logic                             equal_i,
   input  logic                             clear_i,
`ifdef CODE_LOCK_ALARM_EN
   input  logic                             alarm_clr_i,
   output logic                             alarm_o,
`endif
   output logic                             unlocked_o,
   output logic                             fail_o,
   output logic                             locked_out_o,
   output logic                             busy_o,
   output logic [$clog2(MAX_TRIES+1)-1:0]   tries_o
);

   localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
   localparam int unsigned TMR_W = timer_width(OPEN_CYCLES, LOCKOUT_CYCLES);

   lock_state_e      state_q, state_d;
   logic [TRY_W-1:0] tries_q, tries_d;
   logic             unlocked_q, unlocked_d;
   logic             fail_q, fail_d;
   logic             locked_q, locked_d;
   logic             busy_q, busy_d;

   logic             tmr_load;
   logic [TMR_W-1:0] tmr_value;
   logic             tmr_en;
   logic             tmr_zero;

   // One timer serves both the open window and the lockout window.
   cycle_timer #(
      .W (TMR_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (tmr_load),
      .value_i  (tmr_value),
      .enable_i (tmr_en),
      .zero     (tmr_zero)
   );

   // Next-state, tries counter and registered-output decode.
   always_comb begin
      state_d   = state_q;
      tries_d   = tries_q;
      fail_d    = 1'b0;
      tmr_load  = 1'b0;
      tmr_value = '0;
      tmr_en    = 1'b0;

      case (state_q)
         IDLE: begin
            if (check_i) begin
               if (equal_i) begin
                  state_d   = OPEN;
                  tries_d   = '0;
                  tmr_load  = 1'b1;
                  tmr_value = TMR_W'(OPEN_CYCLES - 1);
               end else begin
                  fail_d = 1'b1;
                  if (tries_q != TRY_W'(MAX_TRIES)) begin
                     tries_d = tries_q + TRY_W'(1);
                  end
                  if (tries_d == TRY_W'(MAX_TRIES)) begin
                     state_d   = LOCKOUT;
                     tmr_load  = 1'b1;
                     tmr_value = TMR_W'(LOCKOUT_CYCLES - 1);
                  end
               end
            end
         end
         OPEN: begin
            // Relock request wins over the window still running.
            if (clear_i || tmr_zero) begin
               state_d = IDLE;
            end else begin
               tmr_en = 1'b1;
            end
         end
         LOCKOUT: begin
            if (tmr_zero) begin
               state_d = IDLE;
               tries_d = '0;
            end else begin
               tmr_en = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tries_d = '0;
         end
      endcase

      unlocked_d = (state_d == OPEN);
      locked_d   = (state_d == LOCKOUT);
      busy_d     = unlocked_d | locked_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tries_q    <= '0;
         unlocked_q <= 1'b0;
         fail_q     <= 1'b0;
         locked_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tries_q    <= tries_d;
         unlocked_q <= unlocked_d;
         fail_q     <= fail_d;
         locked_q   <= locked_d;
         busy_q     <= busy_d;
      end
   end

   assign unlocked_o   = unlocked_q;
   assign fail_o       = fail_q;
   assign locked_out_o = locked_q;
   assign busy_o       = busy_q;
   assign tries_o      = tries_q;

`ifdef CODE_LOCK_ALARM_EN
   logic alarm_q, alarm_d;

   // Sticky alarm: set on lockout entry, set beats a coincident clear.
   always_comb begin
      alarm_d = alarm_q;
      if (locked_d && !locked_q) begin
         alarm_d = 1'b1;
      end else if (alarm_clr_i) begin
         alarm_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alarm_q <= 1'b0;
      end else begin
         alarm_q <= alarm_d;
      end
   end

   assign alarm_o = alarm_q;
`endif

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Self-checking bench for code_lock_ctrl: directed scenarios plus random
// traffic, compared every cycle against a remaining-cycles reference model.
// Alarm checks are active when CODE_LOCK_ALARM_EN is defined.
module tb_code_lock_ctrl;

   localparam int unsigned MAXT  = 3;
   localparam int unsigned OPENC = 8;
   localparam int unsigned LOCKC = 16;
   localparam int unsigned TRY_W = $clog2(MAXT + 1);

   logic             clk;
   logic             rst_n;
   logic             check_i;
   logic             equal_i;
   logic             clear_i;
   logic             alarm_clr_i;
   logic             alarm_o;
   logic             unlocked_o;
   logic             fail_o;
   logic             locked_out_o;
   logic             busy_o;
   logic [TRY_W-1:0] tries_o;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: cycles left in each window, consecutive misses.
   int m_open_rem;
   int m_lock_rem;
   int m_tries;
   int m_fail;
   int m_alarm;

   code_lock_ctrl #(
      .MAX_TRIES      (MAXT),
      .OPEN_CYCLES    (OPENC),
      .LOCKOUT_CYCLES (LOCKC)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .check_i      (check_i),
      .equal_i      (equal_i),
      .clear_i      (clear_i),
`ifdef CODE_LOCK_ALARM_EN
      .alarm_clr_i  (alarm_clr_i),
      .alarm_o      (alarm_o),
`endif
      .unlocked_o   (unlocked_o),
      .fail_o       (fail_o),
      .locked_out_o (locked_out_o),
      .busy_o       (busy_o),
      .tries_o      (tries_o)
   );

`ifndef CODE_LOCK_ALARM_EN
   assign alarm_o = 1'b0;
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_open_rem = 0;
      m_lock_rem = 0;
      m_tries    = 0;
      m_fail     = 0;
      m_alarm    = 0;
   endtask

   // One rising edge of the specified behaviour.
   task automatic model_step(input bit chk, input bit eq, input bit clr, input bit aclr);
      bit set_alarm;
      set_alarm = 1'b0;
      m_fail    = 0;
      if (m_open_rem > 0) begin
         m_open_rem = clr ? 0 : m_open_rem - 1;
      end else if (m_lock_rem > 0) begin
         m_lock_rem--;
         if (m_lock_rem == 0) m_tries = 0;
      end else if (chk) begin
         if (eq) begin
            m_open_rem = OPENC;
            m_tries    = 0;
         end else begin
            m_fail = 1;
            if (m_tries < MAXT) m_tries++;
            if (m_tries == MAXT) begin
               m_lock_rem = LOCKC;
               set_alarm  = 1'b1;
            end
         end
      end
      if (set_alarm)  m_alarm = 1;
      else if (aclr)  m_alarm = 0;
   endtask

   task automatic compare_all();
      check_eq("unlocked",   int'(unlocked_o),   (m_open_rem > 0) ? 1 : 0);
      check_eq("fail",       int'(fail_o),       m_fail);
      check_eq("locked_out", int'(locked_out_o), (m_lock_rem > 0) ? 1 : 0);
      check_eq("busy",       int'(busy_o),       (m_open_rem > 0 || m_lock_rem > 0) ? 1 : 0);
      check_eq("tries",      int'(tries_o),      m_tries);
`ifdef CODE_LOCK_ALARM_EN
      check_eq("alarm",      int'(alarm_o),      m_alarm);
`endif
   endtask

   task automatic tick(input bit chk, input bit eq, input bit clr, input bit aclr);
      check_i     = chk;
      equal_i     = eq;
      clear_i     = clr;
      alarm_clr_i = aclr;
      @(posedge clk);
      model_step(chk, eq, clr, aclr);
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Reset asserted between edges must clear outputs without a clock edge.
   task automatic reset_mid();
      check_i     = 1'b0;
      equal_i     = 1'b0;
      clear_i     = 1'b0;
      alarm_clr_i = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_eq("rst_async_unlocked",   int'(unlocked_o),   0);
      check_eq("rst_async_locked_out", int'(locked_out_o), 0);
      compare_all();
      @(posedge clk);
      #1;
      compare_all();
      #3 rst_n = 1'b1;
   endtask

   initial begin
      rst_n       = 1'b0;
      check_i     = 1'b0;
      equal_i     = 1'b0;
      clear_i     = 1'b0;
      alarm_clr_i = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      #3 rst_n = 1'b1;

      // Match opens for the full window.
      idle(2);
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      idle(10);

      // Two misses then a match.
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      idle(10);

      // Three misses back-to-back, checks during lockout ignored.
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 18; i++) tick(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      idle(2);

      // Clear three cycles after a match, then clear in IDLE.
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      idle(2);
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      idle(3);
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      idle(2);

      // Reset in the middle of lockout, then a normal open.
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
      idle(4);
      reset_mid();
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      idle(10);

      // Reset in the middle of open, then a normal open.
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      idle(1);
      reset_mid();
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      idle(10);

      // Alarm stays set after lockout, clears on request.
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
      idle(18);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      idle(2);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         tick(($urandom_range(0, 1) == 1),
              ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 15) == 0));
         if ($urandom_range(0, 399) == 0) reset_mid();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/code_lock_ctrl.md
# code_lock_ctrl

Access-control stage fed by the W-bit code comparator: it samples `equal` when a completed code entry is presented, opens the lock for a fixed window on a match, and counts consecutive mismatches. After MAX_TRIES mismatches it enters a timed lockout. It sits directly downstream of the comparator and drives the actuator and status LEDs.

## Interface
- MAX_TRIES, 3: consecutive mismatches that trigger lockout (≥1).
- OPEN_CYCLES, 8: cycles `unlocked_o` stays high after a match (≥1).
- LOCKOUT_CYCLES, 16: lockout duration in cycles (≥1).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- check_i  in  1  single-cycle strobe: a code entry is complete and `equal_i` is valid this cycle.
- equal_i  in  1  comparator result; sampled only when `check_i`=1.
- clear_i  in  1  relock request; honoured only in OPEN.
- unlocked_o  out  1  lock open.
- fail_o  out  1  one-cycle pulse per rejected mismatch.
- locked_out_o  out  1  lockout in progress.
- busy_o  out  1  high in OPEN or LOCKOUT; `check_i` ignored.
- tries_o  out  $clog2(MAX_TRIES+1)  current consecutive-mismatch count.
- alarm_o, alarm_clr_i  out/in  1  present only with CODE_LOCK_ALARM_EN.

## Operation
- States: IDLE, OPEN, LOCKOUT.
- IDLE, `check_i`=1, `equal_i`=1: go to OPEN, tries←0, timer←OPEN_CYCLES-1.
- IDLE, `check_i`=1, `equal_i`=0: `fail_o` pulses, tries←tries+1. If the new value equals MAX_TRIES, go to LOCKOUT with timer←LOCKOUT_CYCLES-1; otherwise stay in IDLE.
- OPEN: timer decrements each cycle. Go to IDLE when the timer is 0 or `clear_i`=1. `clear_i` takes priority over the timer.
- LOCKOUT: timer decrements each cycle. At 0, go to IDLE with tries←0.
- `check_i` in OPEN or LOCKOUT: no effect. No counting, no `fail_o`.
- `clear_i` outside OPEN: no effect.
- tries saturates at MAX_TRIES and never wraps.
- Timer width is $clog2(max(OPEN_CYCLES,LOCKOUT_CYCLES)). It is an unsigned down-count and never underflows.

## Timing
- All outputs are registered.
- `check_i` at edge N gives `unlocked_o`, `fail_o`, `locked_out_o` and `tries_o` updated after edge N, i.e. 1-cycle latency.
- `unlocked_o` is high for exactly OPEN_CYCLES cycles, unless cut short by `clear_i`. With `clear_i` sampled at edge M, `unlocked_o` is low after edge M.
- `locked_out_o` is high for exactly LOCKOUT_CYCLES cycles. The first accepted check is one cycle after `locked_out_o` falls.
- `busy_o` equals `unlocked_o | locked_out_o`.
- Back-to-back `check_i` in IDLE: every strobe is evaluated. The strobe that reaches MAX_TRIES produces `fail_o` and `locked_out_o` in the same cycle.
- Reset, asserted at any time including mid-OPEN or mid-LOCKOUT:
  - state←IDLE; tries and timer←0.
  - All outputs 0, including `alarm_o`.
  - Takes effect immediately, without waiting for a clock edge.

## Configuration
- CODE_LOCK_ALARM_EN defined:
  - Adds `alarm_o` and `alarm_clr_i`.
  - `alarm_o` sets on entry to LOCKOUT, in the same cycle `locked_out_o` rises.
  - It stays set after the lockout ends and clears only on `alarm_clr_i`=1 or on reset.
  - If set and clear coincide, set wins.
- Not defined: both ports and the alarm register are absent. All other behaviour is identical.

## Structure
- Package `code_lock_pkg`: state enum (IDLE, OPEN, LOCKOUT) and default constants for MAX_TRIES, OPEN_CYCLES and LOCKOUT_CYCLES.
- Sub-module `cycle_timer`: loadable down-counter with inputs load/value/enable and an output `zero`. One instance is shared by OPEN and LOCKOUT.
- The FSM and tries counter are in the top module.

## Test plan
All scenarios use the defaults MAX_TRIES=3, OPEN_CYCLES=8, LOCKOUT_CYCLES=16.
- Reset, then idle: all outputs 0. A check with equal=1 gives `unlocked_o`=1 one cycle later, held 8 cycles, then 0, with `tries_o`=0.
- Two mismatches, then a match: `fail_o` pulses twice and `tries_o` goes 1, 2, then 0, with `unlocked_o` high for 8 cycles.
- Three mismatches back-to-back:
  - `tries_o` goes 1, 2, 3.
  - The third `fail_o` coincides with `locked_out_o` rising; `locked_out_o` stays high 16 cycles.
  - Checks during lockout are ignored; `tries_o` returns to 0 afterwards.
- Match, then `clear_i` 3 cycles later: `unlocked_o` is low the cycle after `clear_i`. `clear_i` pulsed in IDLE has no effect.
- Reset asserted mid-LOCKOUT (cycle 5) and mid-OPEN (cycle 2): outputs are 0 immediately. After release, a match opens normally.
- With CODE_LOCK_ALARM_EN: three mismatches set `alarm_o`. It stays 1 after the lockout ends and clears one cycle after `alarm_clr_i`.
